systempll_lock_seq: RTL and testbench

//  Bring-up and lock supervisor placed directly after the F-tile system PLL.
//  It consumes the PLL's async out_systempll_synthlock and drives that PLL's disable_refclk_monitor input.
//  It qualifies lock, releases downstream TX then RX datapath resets in order, and re-sequences on lock loss.
//  On repeated lock timeouts it pulses a PLL reset and raises a sticky error.

---
 rtl/systempll_lock_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_systempll_lock_seq.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systempll_lock_seq.sv
// ---------------------------------------------------------------------------
// systempll_lock_seq
//
// Bring-up and lock supervisor for the F-tile system PLL. It synchronizes the
// PLL's asynchronous synthlock flag and qualifies lock over a stable window.
// Once lock is qualified it releases the downstream TX datapath reset, then
// the RX datapath reset. On lock loss it re-sequences from the start. If lock
// never arrives it pulses a PLL reset and retries. The final permitted timeout
// parks the block in a sticky ERROR state that only reset can clear.
//
// Ports
//   clk                     free-running management clock
//   reset                   asynchronous active-high reset
//   synthlock_in            PLL synthlock flag, asynchronous to clk
//   disable_refclk_monitor  to PLL; low only while lock is qualified
//   pll_rst                 PLL reset pulse, active high
//   tx_rst                  downstream TX reset, active high
//   rx_rst                  downstream RX reset, active high
//   pll_ready               lock qualified (REL_TX or RUN)
//   lock_err                sticky error, set in ERROR
//   lock_loss_cnt[7:0]      lock losses from REL_TX/RUN, saturating at 255
//   state_o[2:0]            encoded state (WAIT_LOCK=0 ... ERROR=5)
// ---------------------------------------------------------------------------
module systempll_lock_seq #(
    parameter int SYNC_STAGES      = 2,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 1048576,
    parameter int PLL_RST_CYC      = 16,
    parameter int TX_TO_RX_CYC     = 256,
    parameter int MAX_RETRIES      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       synthlock_in,
    output logic       disable_refclk_monitor,
    output logic       pll_rst,
    output logic       tx_rst,
    output logic       rx_rst,
    output logic       pll_ready,
    output logic       lock_err,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] state_o
);

    localparam int TW      = 21;
    localparam int TIM_MAX = 2 ** TW;
    localparam int RW      = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

    // Each window ends on the cycle its timer reaches N-1.
    localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] PLLRST_LAST  = TW'(PLL_RST_CYC - 1);
    localparam logic [TW-1:0] TXRX_LAST    = TW'(TX_TO_RX_CYC - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

    // Catch bad parameterizations at elaboration.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (MAX_RETRIES < 1) begin : g_bad_retries
        $error("MAX_RETRIES must be >= 1");
    end
    if (LOCK_STABLE_CYC < 1 || LOCK_STABLE_CYC > TIM_MAX ||
        LOCK_TIMEOUT_CYC < 1 || LOCK_TIMEOUT_CYC > TIM_MAX ||
        PLL_RST_CYC < 1 || PLL_RST_CYC > TIM_MAX ||
        TX_TO_RX_CYC < 1 || TX_TO_RX_CYC > TIM_MAX) begin : g_bad_cyc
        $error("*_CYC parameters must be in 1..2**21");
    end

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_STABLE    = 3'd1,
        S_REL_TX    = 3'd2,
        S_RUN       = 3'd3,
        S_PLL_RST   = 3'd4,
        S_ERROR     = 3'd5
    } state_t;

    // State and datapath flops
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [RW-1:0]          retry_q, retry_d;
    logic [7:0]             loss_q, loss_d;

    // Registered output flops
    logic       dis_mon_q, dis_mon_d;
    logic       pll_rst_q, pll_rst_d;
    logic       tx_rst_q, tx_rst_d;
    logic       rx_rst_q, rx_rst_d;
    logic       ready_q, ready_d;
    logic       err_q, err_d;
    logic [2:0] state_o_q, state_o_d;

    logic          lock_s;
    logic [RW-1:0] retry_inc;
    logic [7:0]    loss_inc;

    assign lock_s = sync_q[SYNC_STAGES-1];

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], synthlock_in};
        state_d   = state_q;
        timer_d   = timer_q + TW'(1);
        retry_d   = retry_q;
        loss_d    = loss_q;
        retry_inc = retry_q + RW'(1);
        loss_inc  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;

        unique case (state_q)
            S_WAIT_LOCK: begin
                // Lock takes priority over a timeout on the same cycle.
                if (lock_s) begin
                    state_d = S_STABLE;
                    timer_d = '0;
                end else if (timer_q == TIMEOUT_LAST) begin
                    retry_d = retry_inc;
                    timer_d = '0;
                    state_d = (retry_inc == RETRY_LIMIT) ? S_ERROR : S_PLL_RST;
                end
            end
            S_PLL_RST: begin
                // lock_s is ignored while the PLL is being reset.
                if (timer_q == PLLRST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    timer_d = '0;
                end
            end
            S_STABLE: begin
                // A glitch restarts qualification but is not a timeout, so
                // retry is left untouched.
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = S_REL_TX;
                    timer_d = '0;
                    retry_d = '0;
                end
            end
            S_REL_TX: begin
                // Lock loss wins over the TX->RX timer expiring.
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    timer_d = '0;
                    loss_d  = loss_inc;
                end else if (timer_q == TXRX_LAST) begin
                    state_d = S_RUN;
                    timer_d = '0;
                end
            end
            S_RUN: begin
                timer_d = '0;
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    loss_d  = loss_inc;
                end
            end
            S_ERROR: begin
                timer_d = '0;
            end
            default: begin
                state_d = S_WAIT_LOCK;
                timer_d = '0;
            end
        endcase
    end

    // Output decodes of the current state; registered below so every output
    // moves one cycle after the state changes.
    always_comb begin
        dis_mon_d = !(state_q == S_REL_TX || state_q == S_RUN);
        ready_d   =  (state_q == S_REL_TX || state_q == S_RUN);
        tx_rst_d  = !(state_q == S_REL_TX || state_q == S_RUN);
        rx_rst_d  =  (state_q != S_RUN);
        pll_rst_d =  (state_q == S_PLL_RST);
        err_d     =  (state_q == S_ERROR);
        state_o_d =  state_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample
    // their inputs from the same edge regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            state_q   <= S_WAIT_LOCK;
            timer_q   <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            dis_mon_q <= 1'b1;
            pll_rst_q <= 1'b0;
            tx_rst_q  <= 1'b1;
            rx_rst_q  <= 1'b1;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            state_o_q <= 3'd0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            dis_mon_q <= dis_mon_d;
            pll_rst_q <= pll_rst_d;
            tx_rst_q  <= tx_rst_d;
            rx_rst_q  <= rx_rst_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            state_o_q <= state_o_d;
        end
    end

    assign disable_refclk_monitor = dis_mon_q;
    assign pll_rst                = pll_rst_q;
    assign tx_rst                 = tx_rst_q;
    assign rx_rst                 = rx_rst_q;
    assign pll_ready              = ready_q;
    assign lock_err               = err_q;
    assign lock_loss_cnt          = loss_q;
    assign state_o                = state_o_q;

endmodule

// File: tb/tb_systempll_lock_seq.sv
// ---------------------------------------------------------------------------
// tb_systempll_lock_seq
//
// Directed bench for systempll_lock_seq with small parameters:
// SYNC=2 STABLE=8 TIMEOUT=32 PLL_RST=4 TX_TO_RX=4 RETRIES=2.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_systempll_lock_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       synthlock_in;
    logic       disable_refclk_monitor;
    logic       pll_rst;
    logic       tx_rst;
    logic       rx_rst;
    logic       pll_ready;
    logic       lock_err;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state_o;

    int checks   = 0;
    int failures = 0;

    // {dis_mon, pll_rst, tx_rst, rx_rst, pll_ready, lock_err, state_o, cnt}
    localparam logic [16:0] OUTS_RESET = {6'b101100, 3'd0, 8'd0};
    localparam logic [16:0] OUTS_ERROR = {6'b101101, 3'd5, 8'd0};

    systempll_lock_seq #(
        .SYNC_STAGES     (2),
        .LOCK_STABLE_CYC (8),
        .LOCK_TIMEOUT_CYC(32),
        .PLL_RST_CYC     (4),
        .TX_TO_RX_CYC    (4),
        .MAX_RETRIES     (2)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .synthlock_in          (synthlock_in),
        .disable_refclk_monitor(disable_refclk_monitor),
        .pll_rst               (pll_rst),
        .tx_rst                (tx_rst),
        .rx_rst                (rx_rst),
        .pll_ready             (pll_ready),
        .lock_err              (lock_err),
        .lock_loss_cnt         (lock_loss_cnt),
        .state_o               (state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] outs_now();
        return {disable_refclk_monitor, pll_rst, tx_rst, rx_rst, pll_ready,
                lock_err, state_o, lock_loss_cnt};
    endfunction

    // Holds reset for two cycles with synthlock low; returns on a falling
    // edge just after reset deasserts.
    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        synthlock_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (outs_now() !== OUTS_RESET) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected %b", outs_now(), OUTS_RESET);
        end
    endtask

    task automatic test_lock_latency();
        int n;
        do_reset();
        synthlock_in = 1'b1;
        n = 0;
        while (pll_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n !== 12) begin
            failures++;
            $display("FAIL ready_latency: got %0d cycles expected 12", n);
        end
        checks++;
        if (outs_now() !== {6'b000110, 3'd2, 8'd0}) begin
            failures++;
            $display("FAIL rel_tx_outputs: got %b expected %b", outs_now(), {6'b000110, 3'd2, 8'd0});
        end
        n = 0;
        while (rx_rst !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL tx_to_rx_gap: got %0d cycles expected 4", n);
        end
        checks++;
        if (outs_now() !== {6'b000010, 3'd3, 8'd0}) begin
            failures++;
            $display("FAIL run_outputs: got %b expected %b", outs_now(), {6'b000010, 3'd3, 8'd0});
        end
    endtask

    task automatic test_glitch();
        int n;
        bit saw_wait, saw_prst;
        do_reset();
        synthlock_in = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (state_o !== 3'd1) begin
            failures++;
            $display("FAIL glitch_pre_stable: got state %0d expected 1", state_o);
        end
        synthlock_in = 1'b0;
        @(negedge clk);
        synthlock_in = 1'b1;
        n = 0; saw_wait = 0; saw_prst = 0;
        while (pll_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (state_o === 3'd0) saw_wait = 1;
            if (pll_rst === 1'b1) saw_prst = 1;
        end
        checks++;
        if (n !== 12) begin
            failures++;
            $display("FAIL glitch_requalify: got %0d cycles expected 12", n);
        end
        checks++;
        if (saw_wait !== 1'b1) begin
            failures++;
            $display("FAIL glitch_wait_lock: got saw_wait=%0d expected 1", saw_wait);
        end
        checks++;
        if (saw_prst !== 1'b0) begin
            failures++;
            $display("FAIL glitch_no_pll_rst: got saw_pll_rst=%0d expected 0", saw_prst);
        end
    endtask

    // Lock first seen by WAIT_LOCK on exactly the timeout cycle.
    task automatic test_lock_wins_timeout();
        int n;
        bit saw_prst;
        do_reset();
        repeat (29) @(negedge clk);
        synthlock_in = 1'b1;
        n = 0; saw_prst = 0;
        while (pll_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (pll_rst === 1'b1) saw_prst = 1;
        end
        checks++;
        if (n !== 12) begin
            failures++;
            $display("FAIL lock_wins_latency: got %0d cycles expected 12", n);
        end
        checks++;
        if (saw_prst !== 1'b0) begin
            failures++;
            $display("FAIL lock_wins_no_pll_rst: got saw_pll_rst=%0d expected 0", saw_prst);
        end
    endtask

    task automatic test_timeout();
        int n, w;
        do_reset();
        n = 0;
        while (pll_rst !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n !== 33) begin
            failures++;
            $display("FAIL timeout_first_pll_rst: got %0d cycles expected 33", n);
        end
        w = 0;
        while (pll_rst === 1'b1 && w < 100) begin w++; @(negedge clk); end
        checks++;
        if (w !== 4) begin
            failures++;
            $display("FAIL pll_rst_width: got %0d cycles expected 4", w);
        end
        n = 0;
        while (lock_err !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n !== 32) begin
            failures++;
            $display("FAIL second_timeout_error: got %0d cycles expected 32", n);
        end
        checks++;
        if (outs_now() !== OUTS_ERROR) begin
            failures++;
            $display("FAIL error_outputs: got %b expected %b", outs_now(), OUTS_ERROR);
        end
        synthlock_in = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (outs_now() !== OUTS_ERROR) begin
            failures++;
            $display("FAIL error_terminal: got %b expected %b", outs_now(), OUTS_ERROR);
        end
    endtask

    task automatic test_lock_loss();
        int n;
        do_reset();
        synthlock_in = 1'b1;
        n = 0;
        while (rx_rst !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (state_o !== 3'd3) begin
            failures++;
            $display("FAIL loss_reach_run: got state %0d expected 3", state_o);
        end
        synthlock_in = 1'b0;
        n = 0;
        while (tx_rst !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL loss_reaction: got %0d cycles expected 4", n);
        end
        checks++;
        if (outs_now() !== {6'b101100, 3'd0, 8'd1}) begin
            failures++;
            $display("FAIL loss_outputs: got %b expected %b", outs_now(), {6'b101100, 3'd0, 8'd1});
        end
        synthlock_in = 1'b1;
        n = 0;
        while (pll_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n !== 12) begin
            failures++;
            $display("FAIL relock_latency: got %0d cycles expected 12", n);
        end
        checks++;
        if (outs_now() !== {6'b000110, 3'd2, 8'd1}) begin
            failures++;
            $display("FAIL relock_outputs: got %b expected %b", outs_now(), {6'b000110, 3'd2, 8'd1});
        end
    endtask

    // Lock loss reaches REL_TX on the same cycle its timer expires.
    task automatic test_loss_priority();
        int n;
        bit saw_run;
        do_reset();
        synthlock_in = 1'b1;
        n = 0;
        while (pll_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        synthlock_in = 1'b0;
        saw_run = 0;
        repeat (6) begin
            @(negedge clk);
            if (state_o === 3'd3 || rx_rst === 1'b0) saw_run = 1;
        end
        checks++;
        if (saw_run !== 1'b0) begin
            failures++;
            $display("FAIL loss_priority_no_run: got saw_run=%0d expected 0", saw_run);
        end
        checks++;
        if (outs_now() !== {6'b101100, 3'd0, 8'd1}) begin
            failures++;
            $display("FAIL loss_priority_outputs: got %b expected %b", outs_now(), {6'b101100, 3'd0, 8'd1});
        end
    endtask

    task automatic test_saturation();
        int n, timeouts;
        do_reset();
        timeouts = 0;
        for (int i = 1; i <= 300; i++) begin
            synthlock_in = 1'b1;
            n = 0;
            while (pll_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) timeouts++;
            synthlock_in = 1'b0;
            n = 0;
            while (pll_ready !== 1'b0 && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) timeouts++;
            if (i == 254) begin
                checks++;
                if (lock_loss_cnt !== 8'd254) begin
                    failures++;
                    $display("FAIL loss_cnt_254: got %0d expected 254", lock_loss_cnt);
                end
            end
        end
        checks++;
        if (timeouts !== 0) begin
            failures++;
            $display("FAIL sat_handshake: got %0d timeouts expected 0", timeouts);
        end
        checks++;
        if (lock_loss_cnt !== 8'd255) begin
            failures++;
            $display("FAIL loss_cnt_saturate: got %0d expected 255", lock_loss_cnt);
        end
    endtask

    task automatic test_reset_midop();
        int n;
        // Continue from the saturated count so reset must clear it.
        synthlock_in = 1'b1;
        n = 0;
        while (pll_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (outs_now() !== {6'b000110, 3'd2, 8'd255}) begin
            failures++;
            $display("FAIL midop_pre_rel_tx: got %b expected %b", outs_now(), {6'b000110, 3'd2, 8'd255});
        end
        reset = 1'b1;
        #1;
        checks++;
        if (outs_now() !== OUTS_RESET) begin
            failures++;
            $display("FAIL reset_in_rel_tx: got %b expected %b", outs_now(), OUTS_RESET);
        end
        do_reset();
        n = 0;
        while (lock_err !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (lock_err !== 1'b1) begin
            failures++;
            $display("FAIL midop_reach_error: got lock_err=%0d expected 1", lock_err);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (outs_now() !== OUTS_RESET) begin
            failures++;
            $display("FAIL reset_in_error: got %b expected %b", outs_now(), OUTS_RESET);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        synthlock_in = 1'b0;
        #2;
        test_reset();
        test_lock_latency();
        test_glitch();
        test_lock_wins_timeout();
        test_timeout();
        test_lock_loss();
        test_loss_priority();
        test_saturation();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
